// File: rtl/sr_mcycle_control_if.sv
// Control bus between the multi-cycle controller and its datapath/memory.
//   master : controller side (receives cmd fields, flags; drives strobes/status)
//   slave  : datapath side (drives cmd fields, aluZero, memReady; observes strobes)
//   cmdOp/cmdF3/cmdF7 : instruction register fields
//   aluZero, memReady : datapath/memory status
//   memReq, memWe, irWrite, pcWrite, pcSrc, regWrite, aluSrc, wdSrc, aluControl : strobes
//   illegal, busErr   : sticky error flags; state : debug state code
interface sr_mcycle_control_if #(
  parameter int unsigned ALUC_W = 3
);
  logic [6:0]        cmdOp;
  logic [2:0]        cmdF3;
  logic [6:0]        cmdF7;
  logic              aluZero;
  logic              memReady;
  logic              memReq;
  logic              memWe;
  logic              irWrite;
  logic              pcWrite;
  logic              pcSrc;
  logic              regWrite;
  logic              aluSrc;
  logic [1:0]        wdSrc;
  logic [ALUC_W-1:0] aluControl;
  logic              illegal;
  logic              busErr;
  logic [2:0]        state;

  modport master (
    input  cmdOp, cmdF3, cmdF7, aluZero, memReady,
    output memReq, memWe, irWrite, pcWrite, pcSrc, regWrite, aluSrc, wdSrc,
           aluControl, illegal, busErr, state
  );

  modport slave (
    output cmdOp, cmdF3, cmdF7, aluZero, memReady,
    input  memReq, memWe, irWrite, pcWrite, pcSrc, regWrite, aluSrc, wdSrc,
           aluControl, illegal, busErr, state
  );
endinterface

// File: rtl/sr_mcycle_control.sv
// Multi-cycle RV-subset controller: FETCH/DECODE/EXEC/MEM/WB with a per-phase
// memory wait timeout and sticky illegal/bus-error trap.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sr_mcycle_control_if.master (cmd fields in, strobes/status out)
module sr_mcycle_control #(
  parameter int unsigned ALUC_W  = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sr_mcycle_control_if.master   bus
);

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_SRL  = 3'd3;
  localparam logic [2:0] ALU_SLTU = 3'd4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_ILL, CL_RTYPE, CL_ADDI, CL_LUI, CL_BEQ, CL_BNE, CL_LW, CL_SW
  } cls_t;

  state_t     state;
  logic [7:0] waitCnt;
  logic       illegal;
  logic       busErr;

  cls_t       cls;
  logic [2:0] rAluc;

  logic       memReq, memWe, irWrite, pcWrite, pcSrc, regWrite, aluSrc;
  logic [1:0] wdSrc;
  logic [2:0] aluc;

  // Instruction class and R-type ALU op from the instruction register fields
  always_comb begin
    cls   = CL_ILL;
    rAluc = ALU_ADD;
    case (bus.cmdOp)
      OP_R: begin
        if (bus.cmdF7 == 7'b0000000) begin
          case (bus.cmdF3)
            3'b000:  begin cls = CL_RTYPE; rAluc = ALU_ADD;  end
            3'b110:  begin cls = CL_RTYPE; rAluc = ALU_OR;   end
            3'b101:  begin cls = CL_RTYPE; rAluc = ALU_SRL;  end
            3'b011:  begin cls = CL_RTYPE; rAluc = ALU_SLTU; end
            default: cls = CL_ILL;
          endcase
        end else if (bus.cmdF7 == 7'b0100000 && bus.cmdF3 == 3'b000) begin
          cls   = CL_RTYPE;
          rAluc = ALU_SUB;
        end
      end
      OP_IMM:   if (bus.cmdF3 == 3'b000) cls = CL_ADDI;
      OP_LUI:   cls = CL_LUI;
      OP_BR: begin
        if (bus.cmdF3 == 3'b000)      cls = CL_BEQ;
        else if (bus.cmdF3 == 3'b001) cls = CL_BNE;
      end
      OP_LOAD:  if (bus.cmdF3 == 3'b010) cls = CL_LW;
      OP_STORE: if (bus.cmdF3 == 3'b010) cls = CL_SW;
      default:  cls = CL_ILL;
    endcase
  end

  // State register, memory wait counter and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      waitCnt <= 8'd0;
      illegal <= 1'b0;
      busErr  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.memReady) begin
            state <= DECODE;
          end else if (waitCnt == 8'(TIMEOUT)) begin
            state  <= TRAP;
            busErr <= 1'b1;
          end else begin
            waitCnt <= 8'(waitCnt + 8'd1);
          end
        end
        DECODE: begin
          case (cls)
            CL_ILL: begin
              state   <= TRAP;
              illegal <= 1'b1;
            end
            CL_LW, CL_SW: begin
              state   <= MEM;
              waitCnt <= 8'd0;
            end
            default: state <= EXEC;
          endcase
        end
        EXEC: begin
          state   <= FETCH;
          waitCnt <= 8'd0;
        end
        MEM: begin
          if (bus.memReady) begin
            state   <= (cls == CL_SW) ? FETCH : WB;
            waitCnt <= 8'd0;
          end else if (waitCnt == 8'(TIMEOUT)) begin
            state  <= TRAP;
            busErr <= 1'b1;
          end else begin
            waitCnt <= 8'(waitCnt + 8'd1);
          end
        end
        WB: begin
          state   <= FETCH;
          waitCnt <= 8'd0;
        end
        TRAP: state <= TRAP;
        default: begin
          state   <= TRAP;
          illegal <= 1'b1;
        end
      endcase
    end
  end

  // Strobes decoded from the state register and cmd fields; forced low in reset
  always_comb begin
    memReq   = 1'b0;
    memWe    = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    pcSrc    = 1'b0;
    regWrite = 1'b0;
    aluSrc   = 1'b0;
    wdSrc    = 2'd0;
    aluc     = ALU_ADD;
    if (rst_n) begin
      case (state)
        FETCH: begin
          memReq  = 1'b1;
          irWrite = bus.memReady;
        end
        EXEC: begin
          case (cls)
            CL_RTYPE: begin
              regWrite = 1'b1;
              aluc     = rAluc;
              pcWrite  = 1'b1;
            end
            CL_ADDI: begin
              regWrite = 1'b1;
              aluSrc   = 1'b1;
              pcWrite  = 1'b1;
            end
            CL_LUI: begin
              regWrite = 1'b1;
              wdSrc    = 2'd1;
              pcWrite  = 1'b1;
            end
            CL_BEQ: begin
              aluc    = ALU_SUB;
              pcWrite = 1'b1;
              pcSrc   = bus.aluZero;
            end
            CL_BNE: begin
              aluc    = ALU_SUB;
              pcWrite = 1'b1;
              pcSrc   = ~bus.aluZero;
            end
            default: ;
          endcase
        end
        MEM: begin
          memReq  = 1'b1;
          aluSrc  = 1'b1;
          memWe   = (cls == CL_SW);
          pcWrite = bus.memReady && (cls == CL_SW);
        end
        WB: begin
          regWrite = 1'b1;
          wdSrc    = 2'd2;
          pcWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.memReq     = memReq;
  assign bus.memWe      = memWe;
  assign bus.irWrite    = irWrite;
  assign bus.pcWrite    = pcWrite;
  assign bus.pcSrc      = pcSrc;
  assign bus.regWrite   = regWrite;
  assign bus.aluSrc     = aluSrc;
  assign bus.wdSrc      = wdSrc;
  assign bus.aluControl = ALUC_W'(aluc);
  assign bus.illegal    = illegal;
  assign bus.busErr     = busErr;
  assign bus.state      = state;

endmodule

// File: tb/tb_sr_mcycle_control.sv
// Directed bench for sr_mcycle_control (TIMEOUT=4 instance).
module tb_sr_mcycle_control;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sr_mcycle_control_if #(.ALUC_W(3)) bus ();

  sr_mcycle_control #(.ALUC_W(3), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // memReq, memWe, irWrite, pcWrite, pcSrc, regWrite, aluSrc packed for "no strobes" checks
  function automatic logic [7:0] strobes();
    return {1'b0, bus.memReq, bus.memWe, bus.irWrite, bus.pcWrite,
            bus.pcSrc, bus.regWrite, bus.aluSrc};
  endfunction

  task automatic setCmd(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.cmdOp = op;
    bus.cmdF3 = f3;
    bus.cmdF7 = f7;
  endtask

  // Zero-wait FETCH then DECODE; returns during the DECODE cycle
  task automatic fetchDecode(input string tag, input logic [6:0] op,
                             input logic [2:0] f3, input logic [6:0] f7);
    @(negedge clk);
    setCmd(op, f3, f7);
    bus.memReady = 1'b1;
    #1;
    chk({tag, "_fetch_state"}, 8'(bus.state), 8'd0);
    chk({tag, "_irWrite"}, 8'(bus.irWrite), 8'd1);
    @(negedge clk);
    bus.memReady = 1'b0;
    #1;
    chk({tag, "_decode_state"}, 8'(bus.state), 8'd1);
    chk({tag, "_decode_strobes"}, strobes(), 8'd0);
  endtask

  localparam logic [6:0] OPR = 7'b0110011;
  logic [2:0] rF3  [4];
  logic [6:0] rF7  [4];
  logic [2:0] rAlu [4];

  initial begin
    checks   = 0;
    failures = 0;
    rF3[0] = 3'b000; rF7[0] = 7'b0100000; rAlu[0] = 3'd1; // sub
    rF3[1] = 3'b110; rF7[1] = 7'b0000000; rAlu[1] = 3'd2; // or
    rF3[2] = 3'b101; rF7[2] = 7'b0000000; rAlu[2] = 3'd3; // srl
    rF3[3] = 3'b011; rF7[3] = 7'b0000000; rAlu[3] = 3'd4; // sltu

    rst_n        = 1'b0;
    bus.memReady = 1'b0;
    bus.aluZero  = 1'b0;
    setCmd(OPR, 3'b000, 7'b0000000);
    #3;
    chk("rst_state", 8'(bus.state), 8'd0);
    chk("rst_illegal", 8'(bus.illegal), 8'd0);
    chk("rst_busErr", 8'(bus.busErr), 8'd0);
    chk("rst_strobes", strobes(), 8'd0);
    @(negedge clk); #1;
    chk("rst_hold_memReq", 8'(bus.memReq), 8'd0);

    // add: irWrite at cycle 0, EXEC at cycle 2
    @(negedge clk);
    rst_n        = 1'b1;
    bus.memReady = 1'b1;
    #1;
    chk("first_memReq", 8'(bus.memReq), 8'd1);
    chk("add_irWrite", 8'(bus.irWrite), 8'd1);
    @(negedge clk);
    bus.memReady = 1'b0;
    #1;
    chk("add_decode_state", 8'(bus.state), 8'd1);
    chk("add_decode_strobes", strobes(), 8'd0);
    @(negedge clk); #1;
    chk("add_exec_state", 8'(bus.state), 8'd2);
    chk("add_regWrite", 8'(bus.regWrite), 8'd1);
    chk("add_pcWrite", 8'(bus.pcWrite), 8'd1);
    chk("add_pcSrc", 8'(bus.pcSrc), 8'd0);
    chk("add_aluSrc", 8'(bus.aluSrc), 8'd0);
    chk("add_aluc", 8'(bus.aluControl), 8'd0);

    for (int i = 0; i < 4; i++) begin
      fetchDecode("rtype", OPR, rF3[i], rF7[i]);
      @(negedge clk); #1;
      chk("rtype_exec_state", 8'(bus.state), 8'd2);
      chk("rtype_aluc", 8'(bus.aluControl), 8'(rAlu[i]));
      chk("rtype_regWrite", 8'(bus.regWrite), 8'd1);
      chk("rtype_pcWrite", 8'(bus.pcWrite), 8'd1);
    end

    fetchDecode("addi", 7'b0010011, 3'b000, 7'b1010101);
    @(negedge clk); #1;
    chk("addi_ctl", {bus.regWrite, bus.aluSrc, bus.pcWrite, 5'(bus.aluControl)}, 8'b1110_0000);
    chk("addi_wdSrc", 8'(bus.wdSrc), 8'd0);

    fetchDecode("lui", 7'b0110111, 3'b111, 7'b1111111);
    @(negedge clk); #1;
    chk("lui_ctl", {bus.regWrite, bus.aluSrc, bus.pcWrite, 5'd0}, 8'b1010_0000);
    chk("lui_wdSrc", 8'(bus.wdSrc), 8'd1);

    fetchDecode("beq1", 7'b1100011, 3'b000, 7'b0000000);
    @(negedge clk); bus.aluZero = 1'b1; #1;
    chk("beq1_pc", {bus.pcWrite, bus.pcSrc, bus.regWrite, 5'(bus.aluControl)}, 8'b1100_0001);

    fetchDecode("bne1", 7'b1100011, 3'b001, 7'b0000000);
    @(negedge clk); bus.aluZero = 1'b1; #1;
    chk("bne1_pc", {bus.pcWrite, bus.pcSrc, bus.regWrite, 5'(bus.aluControl)}, 8'b1000_0001);

    fetchDecode("beq0", 7'b1100011, 3'b000, 7'b0000000);
    @(negedge clk); bus.aluZero = 1'b0; #1;
    chk("beq0_pc", {bus.pcWrite, bus.pcSrc, 6'd0}, 8'b1000_0000);

    // sw with zero-wait memory
    fetchDecode("sw", 7'b0100011, 3'b010, 7'b0000000);
    @(negedge clk); bus.memReady = 1'b1; #1;
    chk("sw_state", 8'(bus.state), 8'd3);
    chk("sw_mem", {bus.memReq, bus.memWe, bus.aluSrc, bus.pcWrite, bus.regWrite, 3'd0}, 8'b1111_0000);

    // lw with memReady delayed 3 cycles
    fetchDecode("lw", 7'b0000011, 3'b010, 7'b0000000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.memReady = (i == 3);
      #1;
      chk("lw_mem_state", 8'(bus.state), 8'd3);
      chk("lw_mem_ctl", {bus.memReq, bus.memWe, bus.aluSrc, bus.pcWrite, bus.regWrite, 3'd0}, 8'b1010_0000);
    end
    @(negedge clk); bus.memReady = 1'b0; #1;
    chk("lw_wb_state", 8'(bus.state), 8'd4);
    chk("lw_wb_ctl", {bus.regWrite, bus.pcWrite, bus.memReq, 3'd0, bus.wdSrc}, 8'b1100_0010);

    // memReady arriving exactly at counter == TIMEOUT still completes the fetch
    setCmd(OPR, 3'b000, 7'b0000000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.memReady = (i == 4);
      #1;
      chk("late_fetch_state", 8'(bus.state), 8'd0);
      chk("late_irWrite", 8'(bus.irWrite), (i == 4) ? 8'd1 : 8'd0);
    end
    @(negedge clk); bus.memReady = 1'b0; #1;
    chk("late_decode_state", 8'(bus.state), 8'd1);
    chk("late_busErr", 8'(bus.busErr), 8'd0);
    @(negedge clk); #1;
    chk("late_exec_state", 8'(bus.state), 8'd2);

    // reset in the middle of an lw MEM phase abandons it
    fetchDecode("lwrst", 7'b0000011, 3'b010, 7'b0000000);
    @(negedge clk); #1;
    chk("lwrst_mem_state", 8'(bus.state), 8'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("lwrst_state", 8'(bus.state), 8'd0);
    chk("lwrst_strobes", strobes(), 8'd0);
    @(negedge clk); #1;
    chk("lwrst_hold_strobes", strobes(), 8'd0);

    // fetch timeout: 5 FETCH cycles with no ready, then TRAP with busErr
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("to_fetch_state", 8'(bus.state), 8'd0);
      chk("to_busErr_pre", 8'(bus.busErr), 8'd0);
    end
    @(negedge clk); #1;
    chk("to_state", 8'(bus.state), 8'd5);
    chk("to_busErr", 8'(bus.busErr), 8'd1);
    chk("to_strobes", strobes(), 8'd0);
    @(negedge clk); bus.memReady = 1'b1; #1;
    chk("trap_hold_state", 8'(bus.state), 8'd5);
    chk("trap_hold_strobes", strobes(), 8'd0);
    chk("trap_hold_busErr", 8'(bus.busErr), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("to_rst_busErr", 8'(bus.busErr), 8'd0);
    chk("to_rst_state", 8'(bus.state), 8'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.memReady = 1'b0;

    // illegal opcode traps from DECODE
    fetchDecode("ill", 7'b1111111, 3'b000, 7'b0000000);
    @(negedge clk); #1;
    chk("ill_state", 8'(bus.state), 8'd5);
    chk("ill_flag", 8'(bus.illegal), 8'd1);
    chk("ill_wr", {6'd0, bus.regWrite, bus.pcWrite}, 8'd0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("ill_rst_flag", 8'(bus.illegal), 8'd0);
    chk("ill_rst_state", 8'(bus.state), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_mcycle_control.md
SR_MCYCLE_CONTROL -- requirements
Module: sr_mcycle_control

Interface
REQ-001 Parameter ALUC_W, default 3: width of aluControl; codebase ALU_* encodings are zero-extended to this width.
REQ-002 Parameter TIMEOUT, default 15: maximum memReady wait cycles per memory phase before a bus error; legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates occur on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 cmdOp / cmdF3 / cmdF7  in  7/3/7  fields of the instruction register.
REQ-006 aluZero  in  1  ALU zero flag.
REQ-007 memReady  in  1  memory completes the current request in this cycle.
REQ-008 memReq  out  1  memory request active; memWe  out  1  write (store) request.
REQ-009 irWrite  out  1  load the instruction register; pcWrite  out  1  update PC (one pulse per retired instruction).
REQ-010 pcSrc  out  1  select branch target on pcWrite (0 = PC+4).
REQ-011 regWrite  out  1; aluSrc  out  1 (1 = immediate); wdSrc  out  2 (0 = ALU, 1 = immediate, 2 = memory data).
REQ-012 aluControl  out  ALUC_W; illegal  out  1 (sticky); busErr  out  1 (sticky); state  out  3 (debug).

Function
REQ-013 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 go to TRAP with illegal=1.
REQ-014 Supported instructions: add, or, srl, sltu, sub, addi, lui, beq, bne, lw, sw; the opcode/funct3/funct7 encodings are the codebase RV defines (lw: op 0000011 f3 010; sw: op 0100011 f3 010).
REQ-015 FETCH: memReq=1, memWe=0; on memReady, assert irWrite=1 in that cycle and go to DECODE.
REQ-016 DECODE: no strobes. Unsupported encoding goes to TRAP and sets illegal. lw and sw go to MEM. All other supported instructions go to EXEC.
REQ-017 EXEC (1 cycle), R-type: regWrite=1, aluSrc=0, aluControl per funct; pcWrite=1, pcSrc=0; next state FETCH.
REQ-018 EXEC, addi: regWrite=1, aluSrc=1, ALU_ADD. lui: regWrite=1, wdSrc=1. Both: pcWrite=1, next state FETCH.
REQ-019 EXEC, beq/bne: aluControl=ALU_SUB, regWrite=0, pcWrite=1. pcSrc=aluZero for beq and pcSrc=~aluZero for bne.
REQ-020 MEM: memReq=1, aluSrc=1, ALU_ADD, memWe=1 only for sw.
REQ-021 MEM on memReady: sw asserts pcWrite=1 and goes to FETCH; lw goes to WB.
REQ-022 WB (1 cycle): regWrite=1, wdSrc=2, pcWrite=1; next state FETCH.
REQ-023 Outputs not named for a state are 0; aluControl defaults to ALU_ADD; all strobes are combinational from the state register and the cmd fields.
REQ-024 An 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle in those states while memReady=0.
REQ-025 Timeout: if the counter equals TIMEOUT and memReady=0, go to TRAP and set busErr.
REQ-026 If memReady=1 in the same cycle the counter reaches TIMEOUT, the ready wins and normal progress continues.
REQ-027 TRAP: all strobes 0; illegal and busErr hold their values; exit only by reset.
REQ-028 memReady outside FETCH or MEM is ignored.
REQ-029 Latency with zero-wait memory: R/I/branch 3 cycles, sw 3 cycles, lw 4 cycles (FETCH to the next FETCH).

Reset
REQ-030 With rst_n=0, immediately and regardless of clk: state=FETCH, counter=0, illegal=0, busErr=0.
REQ-031 During reset all strobes are 0, including memReq.
REQ-032 The first memReq asserts in the first cycle after rst_n deasserts.
REQ-033 Reset mid-request (FETCH or MEM) abandons the request; no irWrite, pcWrite or regWrite occurs.

Verification
REQ-034 add (f7 0000000, f3 000, op 0110011) with memReady=1 at every FETCH: irWrite at cycle 0, regWrite=1 and pcWrite=1 at cycle 2, aluControl=ALU_ADD.
REQ-035 beq with aluZero=1 gives pcSrc=1 and pcWrite=1 in EXEC; bne with aluZero=1 gives pcSrc=0 and pcWrite=1.
REQ-036 lw with memReady delayed 3 cycles in MEM: memReq stays high 4 cycles; WB then asserts regWrite=1, wdSrc=2, pcWrite=1; sw asserts memWe=1 and never regWrite.
REQ-037 TIMEOUT=4 with memReady held 0 in FETCH: busErr=1 after 5 FETCH cycles, state=5 afterwards, no strobes. A variant with memReady=1 exactly at counter=4 proceeds to DECODE.
REQ-038 op 1111111: DECODE goes to TRAP, illegal=1, and no regWrite or pcWrite occurs. rst_n pulsed low mid-cycle clears illegal immediately and sets state=0.
